// File: rtl/add_flag_pipe.sv
// ============================================================================
// add_flag_pipe
//
// Pipelined adder that also reports status flags. Each operand pair is
// extended to the result width and added. The result y and the carry,
// overflow, zero and negative flags leave through a valid/ready pipeline
// of LATENCY register stages. All arithmetic is done in front of stage 0.
// Later stages only move the finished result along.
//
// Optional feature macro:
//   ADD_FLAG_SAT_EN  - when defined, an overflowing result saturates
//                      (signed: to max positive / min negative, unsigned:
//                      to all ones). flag_c / flag_v still report the raw
//                      overflow, and flag_z / flag_n follow the saturated y.
//
// Parameters:
//   A_SIGNED, B_SIGNED  operand signedness (sign extension only if both set)
//   A_WIDTH, B_WIDTH    operand widths
//   Y_WIDTH             result width, 1..48
//   LATENCY             register stages from accept to output, 1..3
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   pipeline can accept a pair this cycle
//   a, b       operands
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   y          sum (wrapped, or saturated with ADD_FLAG_SAT_EN)
//   flag_c     unsigned carry-out
//   flag_v     signed overflow
//   flag_z     y is all zero
//   flag_n     y MSB
// ============================================================================
module add_flag_pipe #(
  parameter int A_SIGNED = 0,
  parameter int B_SIGNED = 0,
  parameter int A_WIDTH  = 1,
  parameter int B_WIDTH  = 1,
  parameter int Y_WIDTH  = 1,
  parameter int LATENCY  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Y_WIDTH-1:0] y,
  output logic               flag_c,
  output logic               flag_v,
  output logic               flag_z,
  output logic               flag_n
);

  // Sign extension only applies when both operands are signed.
  localparam bit EXT_SIGNED = (A_SIGNED != 0) && (B_SIGNED != 0);
  localparam int MAX_AB     = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;
  localparam int MAXW       = (MAX_AB > Y_WIDTH) ? MAX_AB : Y_WIDTH;
  // Stage payload: {y, c, v, z, n}
  localparam int DW         = Y_WIDTH + 4;

  logic [MAXW-1:0]    w_aWide;
  logic [MAXW-1:0]    w_bWide;
  logic [Y_WIDTH-1:0] w_aExt;
  logic [Y_WIDTH-1:0] w_bExt;
  logic [Y_WIDTH:0]   w_sum;
  logic [Y_WIDTH-1:0] w_yRaw;
  logic [Y_WIDTH-1:0] w_yFinal;
  logic               w_carry;
  logic               w_ovf;
  logic               w_zero;
  logic               w_neg;
  logic [DW-1:0]      w_stage0Data;
  logic [DW-1:0]      w_outData;

  logic [2:0]         r_valid;
  logic [DW-1:0]      r_data0;
  logic [DW-1:0]      r_data1;
  logic [DW-1:0]      r_data2;

  logic               w_ready0;
  logic               w_ready1;
  logic               w_ready2;

  // Widen both operands to a common width. Narrow operands get extended.
  // Wide operands get truncated later, when the low Y_WIDTH bits are taken.
  always_comb begin
    if (EXT_SIGNED) begin
      w_aWide = MAXW'($signed(a));
      w_bWide = MAXW'($signed(b));
    end else begin
      w_aWide = MAXW'(a);
      w_bWide = MAXW'(b);
    end
  end

  assign w_aExt  = w_aWide[Y_WIDTH-1:0];
  assign w_bExt  = w_bWide[Y_WIDTH-1:0];
  assign w_sum   = {1'b0, w_aExt} + {1'b0, w_bExt};
  assign w_yRaw  = w_sum[Y_WIDTH-1:0];
  assign w_carry = w_sum[Y_WIDTH];

  // Overflow means both operands have the same MSB and the result MSB differs.
  // This is computed the same way in signed and unsigned mode.
  assign w_ovf = (w_aExt[Y_WIDTH-1] == w_bExt[Y_WIDTH-1]) &&
                 (w_yRaw[Y_WIDTH-1] != w_aExt[Y_WIDTH-1]);

`ifdef ADD_FLAG_SAT_EN
  // Clamp an overflowing result. In signed mode the sign of the operands
  // picks the rail. In unsigned mode only carry-out saturates, to all ones.
  always_comb begin
    w_yFinal = w_yRaw;
    if (EXT_SIGNED && w_ovf) begin
      w_yFinal              = {Y_WIDTH{~w_aExt[Y_WIDTH-1]}};
      w_yFinal[Y_WIDTH-1]   = w_aExt[Y_WIDTH-1];
    end else if (!EXT_SIGNED && w_carry) begin
      w_yFinal = '1;
    end
  end
`else
  assign w_yFinal = w_yRaw;
`endif

  // Zero and negative flags follow the value that is actually delivered.
  assign w_zero       = (w_yFinal == '0);
  assign w_neg        = w_yFinal[Y_WIDTH-1];
  assign w_stage0Data = {w_yFinal, w_carry, w_ovf, w_zero, w_neg};

  // Backward ready chain. A stage can load when it is empty or when its
  // content leaves this cycle, so a full pipe still streams one per cycle.
  // Stages beyond LATENCY read as always-ready and are never loaded.
  always_comb begin
    w_ready0 = 1'b1;
    w_ready1 = 1'b1;
    w_ready2 = 1'b1;
    case (LATENCY)
      1: begin
        w_ready0 = !r_valid[0] || out_ready;
      end
      2: begin
        w_ready1 = !r_valid[1] || out_ready;
        w_ready0 = !r_valid[0] || w_ready1;
      end
      default: begin
        w_ready2 = !r_valid[2] || out_ready;
        w_ready1 = !r_valid[1] || w_ready2;
        w_ready0 = !r_valid[0] || w_ready1;
      end
    endcase
  end

  assign in_ready = w_ready0;

  // Pipeline registers. A stage's payload only changes when new valid data
  // arrives, so a stalled output holds y and the flags steady. Reset clears
  // every valid bit and the payloads, so y and the flags read zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
    end else begin
      if (w_ready0) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data0 <= w_stage0Data;
        end
      end
      if ((LATENCY >= 2) && w_ready1) begin
        r_valid[1] <= r_valid[0];
        if (r_valid[0]) begin
          r_data1 <= r_data0;
        end
      end
      if ((LATENCY >= 3) && w_ready2) begin
        r_valid[2] <= r_valid[1];
        if (r_valid[1]) begin
          r_data2 <= r_data1;
        end
      end
    end
  end

  // The last populated stage drives the outputs.
  always_comb begin
    w_outData = r_data0;
    out_valid = r_valid[0];
    if (LATENCY == 2) begin
      w_outData = r_data1;
      out_valid = r_valid[1];
    end else if (LATENCY >= 3) begin
      w_outData = r_data2;
      out_valid = r_valid[2];
    end
  end

  assign {y, flag_c, flag_v, flag_z, flag_n} = w_outData;

endmodule

// File: tb/tb_add_flag_pipe.sv
// ============================================================================
// tb_add_flag_pipe
//
// Self-checking bench for add_flag_pipe. It uses three instances:
//   S : both signed, 8/8 -> 8, LATENCY 1
//   U : unsigned mode (only b declared signed), 8/7 -> 8, LATENCY 3
//   M : both signed, 6/10 -> 8 (sign extension plus truncation), LATENCY 2
//
// Every accepted pair goes into a per-instance queue, with its expected
// result worked out by integer arithmetic on the operand values. Results
// must come out in queue order. A stalled output must hold its value.
// Works with or without ADD_FLAG_SAT_EN.
// ============================================================================
module tb_add_flag_pipe;

  logic clk = 1'b0;
  logic rst_n;

  logic       sInValid, sInReady, sOutValid, sOutReady, sC, sV, sZ, sN;
  logic [7:0] sA, sB, sY;
  logic       uInValid, uInReady, uOutValid, uOutReady, uC, uV, uZ, uN;
  logic [7:0] uA, uY;
  logic [6:0] uB;
  logic       mInValid, mInReady, mOutValid, mOutReady, mC, mV, mZ, mN;
  logic [5:0] mA;
  logic [9:0] mB;
  logic [7:0] mY;

  int nChecks = 0;
  int nErrors = 0;

  logic [51:0] sQ[$];
  logic [51:0] uQ[$];
  logic [51:0] mQ[$];

  logic        sPrevStall = 1'b0, uPrevStall = 1'b0, mPrevStall = 1'b0;
  logic [12:0] sPrevOut, uPrevOut, mPrevOut;

`ifdef ADD_FLAG_SAT_EN
  localparam logic [11:0] EXP_S_100_50 = {8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [11:0] EXP_S_80_80  = {8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [11:0] EXP_U_200_100 = {8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
`else
  localparam logic [11:0] EXP_S_100_50 = {8'h96, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [11:0] EXP_S_80_80  = {8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [11:0] EXP_U_200_100 = {8'h2C, 1'b1, 1'b0, 1'b0, 1'b0};
`endif

  add_flag_pipe #(.A_SIGNED(1), .B_SIGNED(1), .A_WIDTH(8), .B_WIDTH(8),
                  .Y_WIDTH(8), .LATENCY(1)) dutS (
    .clk(clk), .rst_n(rst_n), .in_valid(sInValid), .in_ready(sInReady),
    .a(sA), .b(sB), .out_valid(sOutValid), .out_ready(sOutReady), .y(sY),
    .flag_c(sC), .flag_v(sV), .flag_z(sZ), .flag_n(sN));

  add_flag_pipe #(.A_SIGNED(0), .B_SIGNED(1), .A_WIDTH(8), .B_WIDTH(7),
                  .Y_WIDTH(8), .LATENCY(3)) dutU (
    .clk(clk), .rst_n(rst_n), .in_valid(uInValid), .in_ready(uInReady),
    .a(uA), .b(uB), .out_valid(uOutValid), .out_ready(uOutReady), .y(uY),
    .flag_c(uC), .flag_v(uV), .flag_z(uZ), .flag_n(uN));

  add_flag_pipe #(.A_SIGNED(1), .B_SIGNED(1), .A_WIDTH(6), .B_WIDTH(10),
                  .Y_WIDTH(8), .LATENCY(2)) dutM (
    .clk(clk), .rst_n(rst_n), .in_valid(mInValid), .in_ready(mInReady),
    .a(mA), .b(mB), .out_valid(mOutValid), .out_ready(mOutReady), .y(mY),
    .flag_c(mC), .flag_v(mV), .flag_z(mZ), .flag_n(mN));

  always #5 clk = ~clk;

  // Reference result {y[47:0], c, v, z, n} from integer operand values.
  // Overflow is detected as the signed sum leaving the Y-bit range.
  function automatic logic [51:0] refModel(input int aS, input int bS,
                                           input int aw, input int bw,
                                           input int yw,
                                           input longint aIn, input longint bIn);
    longint mask, half, aV, bV, aE, bE, sum, yv, sa, sb, ss;
    bit ext, c, v;
    ext  = (aS != 0) && (bS != 0);
    mask = (longint'(1) << yw) - 1;
    half = longint'(1) << (yw - 1);
    aV = aIn;
    bV = bIn;
    if (ext && aIn[aw-1]) aV = aIn - (longint'(1) << aw);
    if (ext && bIn[bw-1]) bV = bIn - (longint'(1) << bw);
    aE  = aV & mask;
    bE  = bV & mask;
    sum = aE + bE;
    yv  = sum & mask;
    c   = (sum >> yw) != 0;
    sa  = (aE >= half) ? aE - (mask + 1) : aE;
    sb  = (bE >= half) ? bE - (mask + 1) : bE;
    ss  = sa + sb;
    v   = (ss >= half) || (ss < -half);
`ifdef ADD_FLAG_SAT_EN
    if (ext && v) yv = (sa >= 0) ? half - 1 : half;
    else if (!ext && c) yv = mask;
`endif
    return {48'(yv), c, v, (yv == 0), (((yv >> (yw - 1)) & 1) != 0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the n-th next rising edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboards: at each falling edge, work out which transfers the next
  // rising edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      sQ.delete();
      sPrevStall = 1'b0;
    end else begin
      if (sPrevStall)
        checkOutput("S stall hold", 64'({sOutValid, sY, sC, sV, sZ, sN}), 64'(sPrevOut));
      if (sOutValid && sOutReady) begin
        if (sQ.size() == 0) checkOutput("S spurious out_valid", 64'(sOutValid), 64'd0);
        else checkOutput("S result", 64'({sY, sC, sV, sZ, sN}), 64'(sQ.pop_front()));
      end
      if (sInValid && sInReady)
        sQ.push_back(refModel(1, 1, 8, 8, 8, longint'(sA), longint'(sB)));
      sPrevStall = sOutValid && !sOutReady;
      sPrevOut   = {sOutValid, sY, sC, sV, sZ, sN};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      uQ.delete();
      uPrevStall = 1'b0;
    end else begin
      if (uPrevStall)
        checkOutput("U stall hold", 64'({uOutValid, uY, uC, uV, uZ, uN}), 64'(uPrevOut));
      if (uOutValid && uOutReady) begin
        if (uQ.size() == 0) checkOutput("U spurious out_valid", 64'(uOutValid), 64'd0);
        else checkOutput("U result", 64'({uY, uC, uV, uZ, uN}), 64'(uQ.pop_front()));
      end
      if (uInValid && uInReady)
        uQ.push_back(refModel(0, 1, 8, 7, 8, longint'(uA), longint'(uB)));
      uPrevStall = uOutValid && !uOutReady;
      uPrevOut   = {uOutValid, uY, uC, uV, uZ, uN};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mQ.delete();
      mPrevStall = 1'b0;
    end else begin
      if (mPrevStall)
        checkOutput("M stall hold", 64'({mOutValid, mY, mC, mV, mZ, mN}), 64'(mPrevOut));
      if (mOutValid && mOutReady) begin
        if (mQ.size() == 0) checkOutput("M spurious out_valid", 64'(mOutValid), 64'd0);
        else checkOutput("M result", 64'({mY, mC, mV, mZ, mN}), 64'(mQ.pop_front()));
      end
      if (mInValid && mInReady)
        mQ.push_back(refModel(1, 1, 6, 10, 8, longint'(mA), longint'(mB)));
      mPrevStall = mOutValid && !mOutReady;
      mPrevOut   = {mOutValid, mY, mC, mV, mZ, mN};
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, firstV, lastV, nV, acc;

    // Reset, with a pair offered on S that must not be taken.
    rst_n = 1'b0;
    sInValid = 1'b1; sA = 8'd7; sB = 8'd9; sOutReady = 1'b1;
    uInValid = 1'b0; uA = '0; uB = '0; uOutReady = 1'b1;
    mInValid = 1'b0; mA = '0; mB = '0; mOutReady = 1'b1;
    applyStimulus(3);
    @(negedge clk);
    checkOutput("S reset state", 64'({sOutValid, sInReady, sY, sC, sV, sZ, sN}), 64'({1'b0, 1'b1, 12'h0}));
    checkOutput("U reset state", 64'({uOutValid, uInReady, uY, uC, uV, uZ, uN}), 64'({1'b0, 1'b1, 12'h0}));
    checkOutput("M reset state", 64'({mOutValid, mInReady, mY, mC, mV, mZ, mN}), 64'({1'b0, 1'b1, 12'h0}));
    applyStimulus(1);
    rst_n = 1'b1;
    sInValid = 1'b0;
    applyStimulus(3);
    @(negedge clk);
    checkOutput("S no accept during reset", 64'(sOutValid), 64'd0);
    applyStimulus(1);

    // Signed 100 + 50 overflows; LATENCY 1 shows it right after the accept edge.
    sA = 8'd100; sB = 8'd50; sInValid = 1'b1;
    applyStimulus(1);
    sInValid = 1'b0;
    @(negedge clk);
    checkOutput("S latency 100+50", 64'(sOutValid), 64'd1);
    checkOutput("S 100+50", 64'({sY, sC, sV, sZ, sN}), 64'(EXP_S_100_50));
    applyStimulus(1);

    // Signed -128 + -128.
    sA = 8'h80; sB = 8'h80; sInValid = 1'b1;
    applyStimulus(1);
    sInValid = 1'b0;
    @(negedge clk);
    checkOutput("S latency 80+80", 64'(sOutValid), 64'd1);
    checkOutput("S 80+80", 64'({sY, sC, sV, sZ, sN}), 64'(EXP_S_80_80));
    applyStimulus(1);

    // Unsigned 200 + 100 on the 3-stage pipe, measuring latency.
    uA = 8'd200; uB = 7'd100; uInValid = 1'b1;
    applyStimulus(1);
    uInValid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!uOutValid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("U latency", 64'(lat), 64'd2);
    checkOutput("U 200+100", 64'({uY, uC, uV, uZ, uN}), 64'(EXP_U_200_100));
    applyStimulus(2);

    // Ten back-to-back pairs (i, i+1): results on ten consecutive cycles.
    firstV = -1; lastV = -1; nV = 0;
    for (int j = 0; j < 22; j++) begin
      uInValid = (j < 10);
      uA = 8'(j);
      uB = 7'(j + 1);
      @(negedge clk);
      if (uOutValid) begin
        nV++;
        if (firstV < 0) firstV = j;
        lastV = j;
      end
      applyStimulus(1);
    end
    checkOutput("U stream first valid", 64'(firstV), 64'd3);
    checkOutput("U stream last valid", 64'(lastV), 64'd12);
    checkOutput("U stream count", 64'(nV), 64'd10);

    // Backpressure on the 2-stage pipe: two accepts, then in_ready drops.
    mOutReady = 1'b0; mInValid = 1'b1; acc = 0;
    for (int j = 0; j < 5; j++) begin
      mA = 6'($urandom);
      mB = 10'($urandom);
      @(negedge clk);
      if (mInReady) acc++;
      applyStimulus(1);
    end
    @(negedge clk);
    checkOutput("M accepts before stall", 64'(acc), 64'd2);
    checkOutput("M in_ready stalled", 64'(mInReady), 64'd0);
    applyStimulus(1);
    mOutReady = 1'b1;
    for (int j = 0; j < 5; j++) begin
      mA = 6'($urandom);
      mB = 10'($urandom);
      applyStimulus(1);
    end
    mInValid = 1'b0;
    applyStimulus(6);
    checkOutput("M drained after stall", 64'(mQ.size()), 64'd0);

    // Random traffic with random backpressure on all three instances.
    for (int j = 0; j < 400; j++) begin
      sInValid = ($urandom_range(0, 3) != 0); sA = 8'($urandom); sB = 8'($urandom);
      uInValid = ($urandom_range(0, 3) != 0); uA = 8'($urandom); uB = 7'($urandom);
      mInValid = ($urandom_range(0, 3) != 0); mA = 6'($urandom); mB = 10'($urandom);
      sOutReady = ($urandom_range(0, 3) != 0);
      uOutReady = ($urandom_range(0, 3) != 0);
      mOutReady = ($urandom_range(0, 3) != 0);
      applyStimulus(1);
    end
    sInValid = 1'b0; uInValid = 1'b0; mInValid = 1'b0;
    sOutReady = 1'b1; uOutReady = 1'b1; mOutReady = 1'b1;
    applyStimulus(8);
    checkOutput("S drained", 64'(sQ.size()), 64'd0);
    checkOutput("U drained", 64'(uQ.size()), 64'd0);
    checkOutput("M drained", 64'(mQ.size()), 64'd0);

    // One-cycle reset with two results held in M: neither may come out.
    mOutReady = 1'b0; mInValid = 1'b1;
    mA = 6'($urandom); mB = 10'($urandom);
    applyStimulus(2);
    mInValid = 1'b0;
    rst_n = 1'b0;
    applyStimulus(1);
    rst_n = 1'b1;
    mOutReady = 1'b1;
    @(negedge clk);
    checkOutput("M after reset", 64'({mOutValid, mInReady, mY, mC, mV, mZ, mN}), 64'({1'b0, 1'b1, 12'h0}));
    checkOutput("U after reset", 64'({uOutValid, uInReady, uY, uC, uV, uZ, uN}), 64'({1'b0, 1'b1, 12'h0}));
    checkOutput("S after reset", 64'({sOutValid, sInReady, sY, sC, sV, sZ, sN}), 64'({1'b0, 1'b1, 12'h0}));
    nV = 0;
    for (int j = 0; j < 6; j++) begin
      applyStimulus(1);
      @(negedge clk);
      if (mOutValid) nV++;
    end
    checkOutput("M no post-reset output", 64'(nV), 64'd0);

    applyStimulus(1);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
